// File: rtl/ps2_pkg.sv
// Shared scan codes, key indices, frame FSM encoding and event payload for the PS/2 front end.
package ps2_pkg;

    localparam logic [7:0] SC_E0    = 8'hE0;
    localparam logic [7:0] SC_F0    = 8'hF0;
    localparam logic [7:0] SC_E1    = 8'hE1;
    localparam logic [7:0] SC_00    = 8'h00;
    localparam logic [7:0] SC_FF    = 8'hFF;
    localparam logic [7:0] SC_ESC   = 8'h76;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_P     = 8'h4D;
    localparam logic [7:0] SC_R     = 8'h2D;

    localparam int unsigned KEY_ESC   = 0;
    localparam int unsigned KEY_UP    = 1;
    localparam int unsigned KEY_DOWN  = 2;
    localparam int unsigned KEY_LEFT  = 3;
    localparam int unsigned KEY_RIGHT = 4;
    localparam int unsigned KEY_S     = 5;
    localparam int unsigned KEY_P     = 6;
    localparam int unsigned KEY_R     = 7;

    // Bytes swallowed after the E1 that opens the Pause sequence
    localparam int unsigned E1_SKIP = 7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } frame_state_e;

    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [7:0] code;
    } key_evt_t;

    // One-hot key_held bit for a game-control key; zero for any other code
    function automatic logic [7:0] key_mask(input logic [7:0] code, input logic ext);
        logic [7:0] m;
        m = '0;
        if (ext) begin
            case (code)
                SC_UP:    m[KEY_UP]    = 1'b1;
                SC_DOWN:  m[KEY_DOWN]  = 1'b1;
                SC_LEFT:  m[KEY_LEFT]  = 1'b1;
                SC_RIGHT: m[KEY_RIGHT] = 1'b1;
                default:  m = '0;
            endcase
        end else begin
            case (code)
                SC_ESC:  m[KEY_ESC] = 1'b1;
                SC_S:    m[KEY_S]   = 1'b1;
                SC_P:    m[KEY_P]   = 1'b1;
                SC_R:    m[KEY_R]   = 1'b1;
                default: m = '0;
            endcase
        end
        return m;
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 receive path: pin synchronizers, clock glitch filter, 11-bit deframer with timeout.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 10000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       err_parity,
    output logic       err_frame
);

    localparam int unsigned FW = $clog2(FILTER_LEN) + 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYC) + 1;

    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          filt_clk, filt_prev;
    logic [FW-1:0] filt_cnt;
    logic          strobe_c;

    frame_state_e  state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic          par_q, par_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          byte_valid_d, err_parity_d, err_frame_d;

    // Synchronize both pins and debounce the clock; filtered clock moves only after a stable run
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_s1    <= 1'b1;
            clk_s2    <= 1'b1;
            dat_s1    <= 1'b1;
            dat_s2    <= 1'b1;
            filt_clk  <= 1'b1;
            filt_prev <= 1'b1;
            filt_cnt  <= '0;
        end else begin
            clk_s1    <= ps2_clk;
            clk_s2    <= clk_s1;
            dat_s1    <= ps2_dat;
            dat_s2    <= dat_s1;
            filt_prev <= filt_clk;
            if (clk_s2 != filt_clk) begin
                if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                    filt_clk <= clk_s2;
                    filt_cnt <= '0;
                end else begin
                    filt_cnt <= filt_cnt + FW'(1);
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    // Falling edge of the filtered clock is the bit sample point
    assign strobe_c = filt_prev & ~filt_clk;

    // Frame FSM next state, shift register and idle-timeout counter
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        par_d        = par_q;
        to_cnt_d     = '0;
        byte_valid_d = 1'b0;
        err_parity_d = 1'b0;
        err_frame_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (strobe_c && !dat_s2) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (strobe_c) begin
                    shift_d   = {dat_s2, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (strobe_c) begin
                    par_d   = dat_s2;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (strobe_c) begin
                    state_d = ST_IDLE;
                    if (!dat_s2) begin
                        err_frame_d = 1'b1;
                    end else if ((^shift_q) ^ par_q) begin
                        byte_valid_d = 1'b1;
                    end else begin
                        err_parity_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A stalled keyboard mid-frame aborts the frame
        if (state_q != ST_IDLE && !strobe_c) begin
            if (to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
                state_d     = ST_IDLE;
                err_frame_d = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + TW'(1);
            end
        end
    end

    // Frame FSM state and registered byte/error outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            par_q      <= 1'b0;
            to_cnt_q   <= '0;
            byte_valid <= 1'b0;
            rx_byte    <= '0;
            err_parity <= 1'b0;
            err_frame  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            par_q      <= par_d;
            to_cnt_q   <= to_cnt_d;
            byte_valid <= byte_valid_d;
            err_parity <= err_parity_d;
            err_frame  <= err_frame_d;
            if (byte_valid_d) begin
                rx_byte <= shift_q;
            end
        end
    end

endmodule

// File: rtl/ps2_key_event_ctrl.sv
// PS/2 keyboard front end: prefix sequencing into key events, held-key flags and event FIFO.
module ps2_key_event_ctrl
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 10000,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_release,
    output logic [7:0] key_held,
    output logic       err_parity,
    output logic       err_frame,
    output logic       overflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    logic       rx_valid, rx_err_parity, rx_err_frame;
    logic [7:0] rx_byte;

    logic       ext_q, ext_d, rel_q, rel_d;
    logic [2:0] skip_q, skip_d;
    logic       gen_c;
    key_evt_t   gen_evt;
    logic [7:0] mask_c, key_held_d;

    key_evt_t      mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d, occ_after_pop;
    logic          pop_c, full_c, accept_c;
    key_evt_t      head_d;

    ps2_rx_frame #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_rx (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (PS2_CLK),
        .ps2_dat   (PS2_DAT),
        .byte_valid(rx_valid),
        .rx_byte   (rx_byte),
        .err_parity(rx_err_parity),
        .err_frame (rx_err_frame)
    );

    assign err_parity = rx_err_parity;
    assign err_frame  = rx_err_frame;

    // Prefix sequencer: fold E0/F0 into flags, swallow the Pause tail, emit one event per key byte
    always_comb begin
        ext_d   = ext_q;
        rel_d   = rel_q;
        skip_d  = skip_q;
        gen_c   = 1'b0;
        gen_evt = '0;
        if (rx_err_parity || rx_err_frame) begin
            ext_d  = 1'b0;
            rel_d  = 1'b0;
            skip_d = '0;
        end else if (rx_valid) begin
            if (skip_q != 3'd0) begin
                skip_d = skip_q - 3'd1;
            end else begin
                case (rx_byte)
                    SC_E0: ext_d = 1'b1;
                    SC_F0: rel_d = 1'b1;
                    SC_00, SC_FF: begin
                        ext_d = 1'b0;
                        rel_d = 1'b0;
                    end
                    SC_E1: begin
                        ext_d        = 1'b0;
                        rel_d        = 1'b0;
                        skip_d       = 3'(E1_SKIP);
                        gen_c        = 1'b1;
                        gen_evt.code = SC_E1;
                    end
                    default: begin
                        ext_d        = 1'b0;
                        rel_d        = 1'b0;
                        gen_c        = 1'b1;
                        gen_evt.ext  = ext_q;
                        gen_evt.rel  = rel_q;
                        gen_evt.code = rx_byte;
                    end
                endcase
            end
        end
    end

    // Held-key update for the event being generated this cycle
    always_comb begin
        mask_c     = key_mask(gen_evt.code, gen_evt.ext);
        key_held_d = gen_evt.rel ? (key_held & ~mask_c) : (key_held | mask_c);
    end

    // FIFO bookkeeping; simultaneous push and pop always succeed, even when full
    always_comb begin
        pop_c         = evt_valid & evt_ready;
        full_c        = (count_q == CW'(FIFO_DEPTH));
        accept_c      = gen_c & (~full_c | pop_c);
        count_d       = count_q + CW'(accept_c) - CW'(pop_c);
        rd_ptr_d      = pop_c ? rd_ptr_q + AW'(1) : rd_ptr_q;
        occ_after_pop = count_q - CW'(pop_c);
        head_d        = (occ_after_pop == '0) ? gen_evt : mem[rd_ptr_d];
    end

    // Sequencer flags, held keys, FIFO pointers and registered head outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            ext_q       <= 1'b0;
            rel_q       <= 1'b0;
            skip_q      <= '0;
            key_held    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            evt_valid   <= 1'b0;
            evt_code    <= '0;
            evt_ext     <= 1'b0;
            evt_release <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            ext_q    <= ext_d;
            rel_q    <= rel_d;
            skip_q   <= skip_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            overflow <= gen_c & full_c & ~pop_c;
            if (gen_c) begin
                key_held <= key_held_d;
            end
            if (accept_c) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            evt_valid <= (count_d != '0);
            if (count_d != '0) begin
                evt_code    <= head_d.code;
                evt_ext     <= head_d.ext;
                evt_release <= head_d.rel;
            end else begin
                evt_code    <= '0;
                evt_ext     <= 1'b0;
                evt_release <= 1'b0;
            end
        end
    end

    // Event storage
    always_ff @(posedge clk) begin
        if (accept_c) begin
            mem[wr_ptr_q] <= gen_evt;
        end
    end

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Directed bench for ps2_key_event_ctrl: bit-banged PS/2 frames, popped-event log, error pulse counts.
module tb_ps2_key_event_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       PS2_CLK, PS2_DAT;
    logic       evt_valid, evt_ready;
    logic [7:0] evt_code;
    logic       evt_ext, evt_release;
    logic [7:0] key_held;
    logic       err_parity, err_frame, overflow;

    int total = 0;
    int bad   = 0;
    int n_par = 0;
    int n_frm = 0;
    int n_ovf = 0;
    logic [9:0] evq[$];

    ps2_key_event_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .PS2_CLK    (PS2_CLK),
        .PS2_DAT    (PS2_DAT),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_code   (evt_code),
        .evt_ext    (evt_ext),
        .evt_release(evt_release),
        .key_held   (key_held),
        .err_parity (err_parity),
        .err_frame  (err_frame),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Log accepted events as {ext, rel, code} and count error pulses
    always @(negedge clk) begin
        if (evt_valid === 1'b1 && evt_ready === 1'b1) evq.push_back({evt_ext, evt_release, evt_code});
        if (err_parity === 1'b1) n_par++;
        if (err_frame === 1'b1) n_frm++;
        if (overflow === 1'b1) n_ovf++;
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        PS2_DAT = b;
        cycles(10);
        PS2_CLK = 1'b0;
        cycles(20);
        PS2_CLK = 1'b1;
        cycles(10);
    endtask

    task automatic send_frame(input logic [7:0] code, input logic bad_par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(code[i]);
        send_bit(bad_par ? ^code : ~^code);
        send_bit(1'b1);
    endtask

    task automatic clear_mon();
        evq.delete();
        n_par = 0;
        n_frm = 0;
        n_ovf = 0;
    endtask

    function automatic logic [9:0] ev_at(input int i);
        return (evq.size() > i) ? evq[i] : 10'h3FF;
    endfunction

    task automatic test_reset();
        reset = 1'b1; PS2_CLK = 1'b1; PS2_DAT = 1'b1; evt_ready = 1'b1;
        cycles(4);
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", evt_valid); end
        total++; if ({evt_ext, evt_release, evt_code} !== 10'h000) begin bad++; $display("FAIL rst_head: got %h want 000", {evt_ext, evt_release, evt_code}); end
        total++; if (key_held !== 8'h00) begin bad++; $display("FAIL rst_held: got %h want 00", key_held); end
        total++; if ({err_parity, err_frame, overflow} !== 3'b000) begin bad++; $display("FAIL rst_pulses: got %b want 000", {err_parity, err_frame, overflow}); end
        reset = 1'b0;
        clear_mon();
        cycles(50);
        total++; if (n_par + n_frm + n_ovf != 0 || evq.size() != 0) begin bad++; $display("FAIL rst_idle: pulses=%0d events=%0d want 0", n_par + n_frm + n_ovf, evq.size()); end
    endtask

    task automatic test_latency();
        logic [7:0] c;
        c = 8'h1C;
        clear_mon();
        evt_ready = 1'b1;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(c[i]);
        send_bit(~^c);
        PS2_DAT = 1'b1;
        cycles(10);
        PS2_CLK = 1'b0;
        // 2 sync + 8 filter cycles put the stop strobe in the cycle after edge 10
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (k == 11) begin
                total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL lat_early: evt_valid=%b want 0", evt_valid); end
            end
            if (k == 12) begin
                total++; if (evt_valid !== 1'b1) begin bad++; $display("FAIL lat_rise: evt_valid=%b want 1", evt_valid); end
                total++; if ({evt_ext, evt_release, evt_code} !== 10'h01C) begin bad++; $display("FAIL lat_head: got %h want 01c", {evt_ext, evt_release, evt_code}); end
            end
        end
        cycles(8);
        PS2_CLK = 1'b1;
        cycles(10);
        total++; if (evq.size() != 1 || ev_at(0) !== 10'h01C) begin bad++; $display("FAIL lat_log: n=%0d ev0=%h want 1 x 01c", evq.size(), ev_at(0)); end
    endtask

    task automatic test_ext_arrow();
        clear_mon();
        send_frame(8'hE0, 1'b0);
        send_frame(8'h75, 1'b0);
        cycles(5);
        total++; if (evq.size() != 1 || ev_at(0) !== 10'h275) begin bad++; $display("FAIL up_make: n=%0d ev0=%h want 1 x 275", evq.size(), ev_at(0)); end
        total++; if (key_held !== 8'h02) begin bad++; $display("FAIL up_held: got %h want 02", key_held); end
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h75, 1'b0);
        cycles(5);
        total++; if (evq.size() != 2 || ev_at(1) !== 10'h375) begin bad++; $display("FAIL up_break: n=%0d ev1=%h want 2 x 375", evq.size(), ev_at(1)); end
        total++; if (key_held !== 8'h00) begin bad++; $display("FAIL up_clear: got %h want 00", key_held); end
        // keypad 8 (non-extended 75) must not touch the UP bit
        send_frame(8'h75, 1'b0);
        cycles(5);
        total++; if (key_held !== 8'h00 || ev_at(2) !== 10'h075) begin bad++; $display("FAIL keypad: held=%h ev2=%h want 00 075", key_held, ev_at(2)); end
    endtask

    task automatic test_parity();
        clear_mon();
        send_frame(8'h29, 1'b1);
        send_frame(8'h29, 1'b0);
        cycles(5);
        total++; if (n_par != 1 || n_frm != 0) begin bad++; $display("FAIL par_pulses: par=%0d frm=%0d want 1 0", n_par, n_frm); end
        total++; if (evq.size() != 1 || ev_at(0) !== 10'h029) begin bad++; $display("FAIL par_event: n=%0d ev0=%h want 1 x 029", evq.size(), ev_at(0)); end
    endtask

    task automatic test_timeout();
        int waited;
        clear_mon();
        send_bit(1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        cycles(9900);
        total++; if (n_frm != 0) begin bad++; $display("FAIL to_early: err_frame count=%0d want 0", n_frm); end
        waited = 0;
        while (n_frm == 0 && waited < 300) begin cycles(1); waited++; end
        total++; if (n_frm != 1 || n_par != 0) begin bad++; $display("FAIL to_pulse: frm=%0d par=%0d want 1 0", n_frm, n_par); end
        send_frame(8'h1B, 1'b0);
        cycles(5);
        total++; if (evq.size() != 1 || ev_at(0) !== 10'h01B) begin bad++; $display("FAIL to_recover: n=%0d ev0=%h want 1 x 01b", evq.size(), ev_at(0)); end
        total++; if (key_held !== 8'h20) begin bad++; $display("FAIL to_held: got %h want 20", key_held); end
    endtask

    task automatic test_overflow();
        logic [7:0] codes [5];
        codes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24};
        clear_mon();
        evt_ready = 1'b0;
        for (int i = 0; i < 5; i++) send_frame(codes[i], 1'b0);
        cycles(5);
        total++; if (n_ovf != 1) begin bad++; $display("FAIL ovf_pulse: got %0d want 1", n_ovf); end
        total++; if (evt_valid !== 1'b1 || evt_code !== 8'h1C) begin bad++; $display("FAIL ovf_head: valid=%b code=%h want 1 1c", evt_valid, evt_code); end
        evt_ready = 1'b1;
        cycles(10);
        total++; if (evq.size() != 4) begin bad++; $display("FAIL ovf_count: got %0d want 4", evq.size()); end
        for (int i = 0; i < 4; i++) begin
            total++; if (ev_at(i) !== {2'b00, codes[i]}) begin bad++; $display("FAIL ovf_order%0d: got %h want %h", i, ev_at(i), {2'b00, codes[i]}); end
        end
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL ovf_drain: evt_valid=%b want 0", evt_valid); end
    endtask

    task automatic test_pause();
        logic [7:0] seq [9];
        seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h1C};
        clear_mon();
        for (int i = 0; i < 9; i++) send_frame(seq[i], 1'b0);
        cycles(5);
        total++; if (evq.size() != 2 || ev_at(0) !== 10'h0E1 || ev_at(1) !== 10'h01C) begin bad++; $display("FAIL pause: n=%0d ev0=%h ev1=%h want 2 0e1 01c", evq.size(), ev_at(0), ev_at(1)); end
    endtask

    task automatic test_reset_midframe();
        clear_mon();
        send_bit(1'b0);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        total++; if (key_held !== 8'h00 || evt_valid !== 1'b0 || evt_code !== 8'h00) begin bad++; $display("FAIL mid_rst: held=%h valid=%b code=%h want 00 0 00", key_held, evt_valid, evt_code); end
        cycles(30);
        send_frame(8'h76, 1'b0);
        cycles(5);
        total++; if (evq.size() != 1 || ev_at(0) !== 10'h076) begin bad++; $display("FAIL mid_event: n=%0d ev0=%h want 1 x 076", evq.size(), ev_at(0)); end
        total++; if (n_par != 0 || n_frm != 0) begin bad++; $display("FAIL mid_err: par=%0d frm=%0d want 0 0", n_par, n_frm); end
        total++; if (key_held !== 8'h01) begin bad++; $display("FAIL mid_held: got %h want 01", key_held); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_ext_arrow();
        test_parity();
        test_timeout();
        test_overflow();
        test_pause();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_key_event_ctrl.md
Name: ps2_key_event_ctrl

Overview:
- Synchronous PS/2 keyboard front end running entirely on the system clock.
- Oversamples PS2_CLK/PS2_DAT, deframes 11-bit frames and checks parity/stop.
- Sequences the E0/F0/E1 prefix protocol into single key events, queued in a small FIFO with a valid/ready handshake.
- Maintains held-state flags for the game-control keys; sits between the keyboard pins and the game/display logic.

Parameters:
- FILTER_LEN, 8: consecutive equal synced samples before the filtered PS2_CLK changes.
- TIMEOUT_CYC, 10000: idle clk cycles inside a frame before abort (100 us at 100 MHz).
- FIFO_DEPTH, 4: event FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- PS2_CLK  in  1  raw keyboard clock (asynchronous).
- PS2_DAT  in  1  raw keyboard data (asynchronous).
- evt_valid  out  1  FIFO head holds an event.
- evt_ready  in  1  consumer accepts the head this cycle.
- evt_code  out  8  scan code of the head event.
- evt_ext  out  1  head event was E0-prefixed.
- evt_release  out  1  head event was F0-prefixed (break).
- key_held  out  8  [0]ESC [1]UP [2]DOWN [3]LEFT [4]RIGHT [5]S [6]P [7]R.
- err_parity  out  1  one-cycle pulse: parity error.
- err_frame  out  1  one-cycle pulse: bad stop bit or timeout.
- overflow  out  1  one-cycle pulse: event dropped because FIFO full.

Behaviour:
- Reset: all outputs 0, FIFO empty, prefix flags clear, frame FSM IDLE, filtered clock = 1, synchronizers = 1. A partial frame in progress is discarded; no pulse is emitted.
- Input conditioning: 2-FF synchronizer on both pins. The filtered clock toggles only after FILTER_LEN identical synced samples. Its 1->0 transition is the sample strobe; synced PS2_DAT is sampled in that cycle.
- Frame FSM (states IDLE, DATA, PARITY, STOP):
  - IDLE: strobe with data = 0 -> DATA with bit count 0; data = 1 is ignored.
  - DATA: 8 bits shifted LSB first; after the 8th bit -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: on strobe -> IDLE. Byte valid iff stop = 1 and (XOR of data bits ^ parity) = 1. Stop = 0 -> err_frame. Bad parity with good stop -> err_parity only.
  - Timeout: any non-IDLE state with no strobe for TIMEOUT_CYC cycles -> err_frame, IDLE. The counter reloads on every strobe.
- Prefix sequencer, per valid byte:
  - E0 sets ext; F0 sets rel.
  - 00 or FF (keyboard error codes) clears both flags and emits nothing.
  - E1 clears the flags, emits one event {code=E1, ext=0, rel=0} and discards the next 7 valid bytes via a skip counter.
  - Any other byte emits {code, ext, rel} and clears both flags.
  - Any err_parity or err_frame clears ext, rel and the skip counter.
- Latency: with an empty FIFO, evt_valid rises exactly 2 clk cycles after the cycle containing the stop-bit strobe.
- key_held: updated in the same cycle an event is generated, independent of FIFO acceptance. A make event sets the bit; a release event clears it.
  - Matches: ESC=76 (ext=0); UP=75, DOWN=72, LEFT=6B, RIGHT=74 (ext=1); S=1B, P=4D, R=2D (ext=0).
  - Non-ext 75/72/6B/74 (keypad) do not affect the arrow bits.
- FIFO: pop when evt_valid & evt_ready. Push and pop in the same cycle are both honoured, including when full.
  - Push when full without pop: event dropped and overflow pulses; key_held still updates.
  - evt_code/evt_ext/evt_release are don't-care when evt_valid = 0 and are driven 0.
  - The head is stable while evt_valid = 1 and evt_ready = 0.

Decomposition:
- Package ps2_pkg holds:
  - scan-code constants (E0, F0, E1, 00, FF, ESC, UP, DOWN, LEFT, RIGHT, S, P, R);
  - key_held bit indices;
  - frame FSM state encoding;
  - event struct {ext, rel, code[7:0]}.
- Sub-module ps2_rx_frame: synchronizers, filter, frame FSM and timeout. Outputs byte_valid, byte, err_parity, err_frame.
- Prefix sequencer, key_held and FIFO stay in the top level.

Test Plan:
- Frame 1C, odd parity, stop 1; evt_ready = 1 -> one event {1C, ext=0, rel=0}; evt_valid high exactly 2 cycles after the stop strobe.
- Bytes E0 75, then E0 F0 75 -> events {75,1,0}, {75,1,1}; key_held[1] rises after the first event and falls after the second.
- Byte 29 sent with wrong parity, then 29 correct -> err_parity pulses once; exactly one event {29,0,0}.
- Start bit plus 4 data bits, then silence -> err_frame pulses after TIMEOUT_CYC idle cycles; the next full frame 1B decodes correctly and key_held[5] = 1.
- evt_ready = 0; send 5 makes -> 4 queued in order, overflow pulses on the 5th. Raise evt_ready -> 4 events drain in order, then evt_valid = 0.
- Assert reset for 1 cycle mid-frame (after 3 data bits) -> all outputs 0; the following complete frame 76 yields {76,0,0} with no error pulses.
